spi_frame_master: RTL and testbench

SPI master (CPOL=0, CPHA=1) that drives frames into the sniffer's SPI slave command interface, for use by the on-board test harness and the bring-up loopback.
- Frame: header byte, optional INFO byte, then payload bytes; every byte is full duplex.
- Header: {format, read, sec_CMD, CMD[4:0]}.
- Payload bytes come in through a valid/ready handshake; received MISO bytes go out as strobes.

---
 rtl/spi_frame_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_frame_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-1 (CPOL=0, CPHA=1) master clocking header / INFO / payload frames LSB first.
// Latency: GAP_CYC setup, then per byte 1 LOAD cycle + 16*CLK_DIV shift cycles, GAP_CYC between bytes, GAP_CYC hold.
// Backpressure: a write payload byte with tx_valid low parks the frame in STALL (SCLK low, SS low).
// Optional: define SPI_FRAME_MASTER_TIMEOUT_EN to abort a frame after 255 stalled cycles (err set, done pulsed).
module spi_frame_master #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] hdr,
    input  logic [7:0] info,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       SCLK,
    output logic       SS,
    output logic       MOSI,
    input  logic       MISO,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_STALL,
        S_SHIFT,
        S_GAP,
        S_HOLD
    } state_t;

    // Terminal counts for the SCLK half-period and the SS guard gaps.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    state_t     state;
    logic [7:0] hdr_q;      // header captured at accepted start
    logic [7:0] info_q;     // INFO byte captured at accepted start
    logic [7:0] tx_sh;      // outgoing byte, shifted right as bits leave on MOSI
    logic [7:0] rx_sh;      // incoming byte, MISO bits enter at the MSB
    logic [7:0] hcnt;       // clk cycles within the current SCLK half-period
    logic [7:0] gcnt;       // clk cycles within SETUP / GAP / HOLD
    logic [3:0] ecnt;       // SCLK edges within the current byte (16 per byte)
    logic [5:0] byte_idx;   // index of the byte currently being framed
    logic       rx_pend;    // a completed received byte waits to be published
    logic       miso_m;
    logic       miso_s;
`ifdef SPI_FRAME_MASTER_TIMEOUT_EN
    logic [7:0] tcnt;       // cycles spent in STALL without tx_valid
`endif

    logic [5:0] nbytes;
    logic       last_byte;
    logic       is_payload;

    // Frame length: short frames carry one payload byte, long frames carry info[4:0].
    assign nbytes     = hdr_q[7] ? (6'd2 + {1'b0, info_q[4:0]}) : 6'd2;
    assign last_byte  = (byte_idx == (nbytes - 6'd1));
    assign is_payload = (byte_idx != 6'd0) && !(hdr_q[7] && (byte_idx == 6'd1));

    // Two-flop synchroniser for the asynchronous MISO line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miso_m <= 1'b0;
            miso_s <= 1'b0;
        end else begin
            miso_m <= MISO;
            miso_s <= miso_m;
        end
    end

    // Frame sequencer: owns every SPI pin and status output so they all leave flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            hdr_q    <= 8'h00;
            info_q   <= 8'h00;
            tx_sh    <= 8'h00;
            rx_sh    <= 8'h00;
            hcnt     <= 8'h00;
            gcnt     <= 8'h00;
            ecnt     <= 4'h0;
            byte_idx <= 6'd0;
            rx_pend  <= 1'b0;
            tx_ready <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            SCLK     <= 1'b0;
            SS       <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef SPI_FRAME_MASTER_TIMEOUT_EN
            tcnt     <= 8'h00;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;

            // Publish a received byte one cycle after its final falling edge.
            if (rx_pend) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
                rx_pend  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    SCLK <= 1'b0;
                    MOSI <= 1'b0;
                    if (start) begin
                        hdr_q    <= hdr;
                        info_q   <= info;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        SS       <= 1'b0;
                        gcnt     <= 8'h00;
                        byte_idx <= 6'd0;
                        state    <= S_SETUP;
                    end
                end

                // SS low ahead of the first SCLK edge.
                S_SETUP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt  <= 8'h00;
                        state <= S_LOAD;
                    end else begin
                        gcnt <= gcnt + 8'h01;
                    end
                end

                // Pick the next byte; write payload needs a tx handshake.
                S_LOAD: begin
                    hcnt <= 8'h00;
                    ecnt <= 4'h0;
`ifdef SPI_FRAME_MASTER_TIMEOUT_EN
                    tcnt <= 8'h00;
`endif
                    if (!is_payload) begin
                        tx_sh <= (byte_idx == 6'd0) ? hdr_q : info_q;
                        state <= S_SHIFT;
                    end else if (hdr_q[6]) begin
                        // Read frames clock out zeros and leave tx_data alone.
                        tx_sh <= 8'h00;
                        state <= S_SHIFT;
                    end else if (tx_valid) begin
                        tx_sh    <= tx_data;
                        tx_ready <= 1'b1;
                        state    <= S_SHIFT;
                    end else begin
                        state <= S_STALL;
                    end
                end

                // Payload underrun: bus held quiet until data shows up.
                S_STALL: begin
                    if (tx_valid) begin
                        state <= S_LOAD;
                    end
`ifdef SPI_FRAME_MASTER_TIMEOUT_EN
                    else if (tcnt == 8'd254) begin
                        // 255th stalled cycle: give up without clocking a partial byte.
                        SS    <= 1'b1;
                        MOSI  <= 1'b0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 8'h01;
                    end
`endif
                end

                // Eight full SCLK periods; drive on rising, sample on falling.
                S_SHIFT: begin
                    if (hcnt == DIV_LAST) begin
                        hcnt <= 8'h00;
                        ecnt <= ecnt + 4'h1;
                        SCLK <= ~SCLK;
                        if (!SCLK) begin
                            MOSI  <= tx_sh[0];
                            tx_sh <= {1'b0, tx_sh[7:1]};
                        end else begin
                            rx_sh <= {miso_s, rx_sh[7:1]};
                            if (ecnt == 4'd15) begin
                                // Header byte echo is never reported.
                                rx_pend <= (byte_idx != 6'd0);
                                gcnt    <= 8'h00;
                                if (last_byte) begin
                                    state <= S_HOLD;
                                end else begin
                                    byte_idx <= byte_idx + 6'd1;
                                    state    <= S_GAP;
                                end
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 8'h01;
                    end
                end

                // Inter-byte guard with SS still asserted.
                S_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt  <= 8'h00;
                        state <= S_LOAD;
                    end else begin
                        gcnt <= gcnt + 8'h01;
                    end
                end

                // Trailing guard after the last falling edge, then release SS.
                S_HOLD: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt  <= 8'h00;
                        SS    <= 1'b1;
                        MOSI  <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt + 8'h01;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: scoreboard bench for spi_frame_master with an SPI slave model and payload source.
// Expected MOSI bytes, received bytes and per-frame pulse counts are queued when a frame is launched.
// Build with SPI_FRAME_MASTER_TIMEOUT_EN defined to exercise the stall abort path.
module tb_spi_frame_master;

    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] hdr;
    logic [7:0] info;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       SCLK;
    logic       SS;
    logic       MOSI;
    logic       MISO;
    logic       busy;
    logic       done;
    logic       err;

    logic       loop_en;
    logic       miso_slv;
    bit         hold_off;

    assign MISO = loop_en ? MOSI : miso_slv;

    spi_frame_master #(
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hdr      (hdr),
        .info     (info),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .SCLK     (SCLK),
        .SS       (SS),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mosi_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_q[$];
    logic [7:0] slv_q[$];

    int n_sclk;
    int n_txr;
    int n_rxv;
    int n_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_sclk", SCLK, 0);
        check("rst_ss", SS, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    // Payload source: presents the queue head, drops it once the DUT pulses tx_ready.
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_ready && (tx_q.size() > 0)) void'(tx_q.pop_front());
            tx_valid = (tx_q.size() > 0) && !hold_off;
            tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    end

    // Bus monitor + slave model: pulse widths, MOSI bytes, received bytes, pulse counts.
    initial begin
        logic       sclk_prev;
        int         bitcnt;
        int         sbit;
        int         hi_w;
        int         lo_w;
        logic [7:0] mbyte;
        logic [7:0] sbyte;
        sclk_prev = 1'b0;
        bitcnt    = 0;
        sbit      = 0;
        hi_w      = 0;
        lo_w      = 0;
        mbyte     = 8'h00;
        sbyte     = 8'h00;
        miso_slv  = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                n_rxv++;
                if (rx_exp.size() > 0) check("rx_data", rx_data, rx_exp.pop_front());
            end
            if (done) n_done++;
            if (tx_ready) n_txr++;
            if (rst && !SS) begin
                if (SCLK && !sclk_prev) begin
                    n_sclk++;
                    if (bitcnt != 0) check("sclk_low_width", lo_w, CLK_DIV);
                    hi_w = 0;
                    if (sbit == 0) sbyte = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
                    miso_slv = sbyte[sbit];
                    sbit = (sbit + 1) % 8;
                end
                if (!SCLK && sclk_prev) begin
                    check("sclk_high_width", hi_w, CLK_DIV);
                    lo_w = 0;
                    mbyte[bitcnt] = MOSI;
                    bitcnt++;
                    if (bitcnt == 8) begin
                        bitcnt = 0;
                        if (mosi_exp.size() > 0) check("mosi_byte", mbyte, mosi_exp.pop_front());
                    end
                end
                if (SCLK) hi_w++;
                else lo_w++;
            end else begin
                bitcnt = 0;
                sbit   = 0;
            end
            sclk_prev = SCLK;
        end
    end

    // Launch one frame, queue its expectations, optionally starve the payload, then audit it.
    task automatic run_frame(input logic [7:0] h, input logic [7:0] inf, input bit lp,
                             input int stall, input bit exp_abort);
        logic [7:0] b[$];
        logic [7:0] s[$];
        int n;
        int pre;
        int npay;
        int clocked;
        int lat;
        int stall_cnt;
        bit rd;
        bit got_done;
        rd      = h[6];
        n       = h[7] ? (2 + int'(inf[4:0])) : 2;
        pre     = h[7] ? 2 : 1;
        npay    = n - pre;
        clocked = exp_abort ? pre : n;
        n_sclk  = 0;
        n_txr   = 0;
        n_rxv   = 0;
        n_done  = 0;
        loop_en = lp;
        b.push_back(h);
        if (h[7]) b.push_back(inf);
        for (int k = 0; k < npay; k++) begin
            logic [7:0] p;
            p = rd ? 8'h00 : 8'($urandom_range(0, 255));
            b.push_back(p);
            if (!rd) tx_q.push_back(p);
        end
        for (int k = 0; k < n; k++) s.push_back(lp ? b[k] : 8'($urandom_range(0, 255)));
        for (int k = 0; k < clocked; k++) begin
            mosi_exp.push_back(b[k]);
            if (!lp) slv_q.push_back(s[k]);
            if (k > 0) rx_exp.push_back(s[k]);
        end
        hold_off = (stall != 0);

        @(negedge clk);
        hdr   = h;
        info  = inf;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
        check("ss_low_after_start", SS, 0);

        lat       = 0;
        stall_cnt = 0;
        got_done  = 1'b0;
        while (!got_done && (lat < 5000)) begin
            @(negedge clk);
            #1;
            lat++;
            // A start request mid-frame must be ignored.
            if (lat == 20) begin
                hdr   = 8'h7F;
                info  = 8'h1F;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (hold_off && (stall > 0) && (n_sclk == 8 * pre) && !SCLK && (n_txr == 0)) begin
                check("stall_sclk_low", SCLK, 0);
                check("stall_ss_low", SS, 0);
                stall_cnt++;
                if (stall_cnt == stall) hold_off = 1'b0;
            end
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        check("done_seen", got_done, 1);
        if (stall == 0) check("frame_latency", lat, GAP_CYC * (n + 1) + n * (1 + 16 * CLK_DIV));
        check("busy_at_done", busy, 0);
        check("ss_at_done", SS, 1);
        check("err_at_done", err, exp_abort);

        repeat (3) @(negedge clk);
        #1;
        check("sclk_pulses", n_sclk, 8 * clocked);
        check("tx_ready_pulses", n_txr, (rd || exp_abort) ? 0 : npay);
        check("rx_valid_pulses", n_rxv, clocked - 1);
        check("done_pulses", n_done, 1);
        check("mosi_left", mosi_exp.size(), 0);
        check("rx_left", rx_exp.size(), 0);
        tx_q.delete();
        slv_q.delete();
        hold_off = 1'b0;
    endtask

    // Reset asserted while a byte is being shifted must return every output to idle at once.
    task automatic reset_mid_shift();
        int w;
        n_sclk  = 0;
        loop_en = 1'b0;
        tx_q.push_back(8'h3C);
        @(negedge clk);
        hdr   = 8'h01;
        info  = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while ((n_sclk < 5) && (w < 2000)) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("reached_shift", (n_sclk >= 5), 1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        tx_q.delete();
        slv_q.delete();
        mosi_exp.delete();
        rx_exp.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        hdr      = 8'h00;
        info     = 8'h00;
        loop_en  = 1'b0;
        hold_off = 1'b0;
        #17;
        check_reset_outputs();
        #20 rst = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(8'h03, 8'h00, 1'b0, 0, 1'b0);    // short write, tx_valid up before start
        run_frame(8'h81, 8'h03, 1'b1, 0, 1'b0);    // long write, loopback
        run_frame(8'hC2, 8'h02, 1'b0, 0, 1'b0);    // long read, slave data
        run_frame(8'h84, 8'h1F, 1'b1, 0, 1'b0);    // maximum length, 33 bytes
        run_frame(8'h85, 8'h00, 1'b1, 0, 1'b0);    // long format, zero payload
        run_frame(8'h05, 8'h00, 1'b0, 50, 1'b0);   // 50-cycle underrun
`ifdef SPI_FRAME_MASTER_TIMEOUT_EN
        run_frame(8'h06, 8'h00, 1'b0, -1, 1'b1);   // starved until the abort
`else
        run_frame(8'h06, 8'h00, 1'b0, 300, 1'b0);  // long underrun waits it out
`endif
        run_frame(8'h07, 8'h00, 1'b1, 0, 1'b0);    // next start clears err
        reset_mid_shift();
        run_frame(8'h83, 8'h02, 1'b1, 0, 1'b0);    // clean frame after reset

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
